// File: rtl/debug_arb_pkg.sv
// Shared types and constants for the CPU debug-port arbiter.
package debug_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam int GRANT_CNT_W = 16;

endpackage

// File: rtl/debug_arb_stats.sv
// Per-requester saturating grant counters; only built when DEBUG_ARB_STATS_EN is defined.
module debug_arb_stats
    import debug_arb_pkg::*;
(
    input  logic                   clk,
    input  logic                   RSTN,
    input  logic                   grant0,
    input  logic                   grant1,
    output logic [GRANT_CNT_W-1:0] grant_cnt0,
    output logic [GRANT_CNT_W-1:0] grant_cnt1
);

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + GRANT_CNT_W'(1);
            end
            if (grant1 && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + GRANT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debug_port_arbiter.sv
// Two-requester arbiter for the SCPU debug read port. Optional grant statistics
// are enabled with the DEBUG_ARB_STATS_EN macro.
module debug_port_arbiter
    import debug_arb_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic                   clk,
    input  logic                   RSTN,
    input  logic                   req0,
    input  logic                   req1,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [ADDR_W-1:0]      addr1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic [ADDR_W-1:0]      dbg_addr,
    input  logic [DATA_W-1:0]      dbg_data,
    output logic [GRANT_CNT_W-1:0] grant_cnt0,
    output logic [GRANT_CNT_W-1:0] grant_cnt1
);

    // Handshake: a requester holds req (and addr until grant) until it sees its
    // one-cycle ack; rdata is valid exactly in that ack cycle, and a req still
    // high in the ack cycle is arbitrated again as a fresh request.

    localparam logic [2:0] LAT_INIT   = 3'(READ_LAT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_t  state;
    req_id_t     winner;
    logic [2:0]  lat_cnt;
    logic [7:0]  starve;
    logic        any_req;
    logic        pick1;

    always_comb begin
        any_req = req0 | req1;
        pick1   = req1 & (~req0 | (starve == STARVE_LIM));
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state    <= IDLE;
            winner   <= 1'b0;
            lat_cnt  <= '0;
            starve   <= '0;
            dbg_addr <= '0;
            rdata    <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner   <= req_id_t'(pick1);
                        dbg_addr <= pick1 ? addr1 : addr0;
                        lat_cnt  <= LAT_INIT;
                        busy     <= 1'b1;
                        state    <= WAIT;
                        // Requester 1 losing implies both were requesting.
                        if (pick1) begin
                            starve <= '0;
                        end else if (req1 && (starve != STARVE_LIM)) begin
                            starve <= starve + 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt != 3'd0) begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end else begin
                        rdata <= dbg_data;
                        ack0  <= (winner == 1'b0);
                        ack1  <= (winner == 1'b1);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEBUG_ARB_STATS_EN
    logic grant0;
    logic grant1;

    assign grant0 = (state == IDLE) & any_req & ~pick1;
    assign grant1 = (state == IDLE) & any_req & pick1;

    debug_arb_stats u_stats (
        .clk        (clk),
        .RSTN       (RSTN),
        .grant0     (grant0),
        .grant1     (grant1),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_debug_port_arbiter.sv
// Directed bench for debug_port_arbiter: READ_LAT=1 instance (a_*) and READ_LAT=3 instance (b_*).
module tb_debug_port_arbiter;

    logic        clk;
    logic        RSTN;

    logic        a_req0, a_req1, a_ack0, a_ack1, a_busy;
    logic [6:0]  a_addr0, a_addr1, a_dbg_addr;
    logic [31:0] a_rdata, a_dbg_data;
    logic [15:0] a_cnt0, a_cnt1;

    logic        b_req0, b_req1, b_ack0, b_ack1, b_busy;
    logic [6:0]  b_addr0, b_addr1, b_dbg_addr;
    logic [31:0] b_rdata, b_dbg_data;
    logic [15:0] b_cnt0, b_cnt1;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];

    // Port model: data = 0xDEAD in the top half, address in the bottom bits.
    assign a_dbg_data = {16'hDEAD, 9'd0, a_dbg_addr};
    assign b_dbg_data = {16'hDEAD, 9'd0, b_dbg_addr};

    debug_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(1), .STARVE_MAX(15)) u_dut_a (
        .clk(clk), .RSTN(RSTN), .req0(a_req0), .req1(a_req1), .addr0(a_addr0), .addr1(a_addr1),
        .ack0(a_ack0), .ack1(a_ack1), .rdata(a_rdata), .busy(a_busy), .dbg_addr(a_dbg_addr),
        .dbg_data(a_dbg_data), .grant_cnt0(a_cnt0), .grant_cnt1(a_cnt1)
    );

    debug_port_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(3), .STARVE_MAX(15)) u_dut_b (
        .clk(clk), .RSTN(RSTN), .req0(b_req0), .req1(b_req1), .addr0(b_addr0), .addr1(b_addr1),
        .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy), .dbg_addr(b_dbg_addr),
        .dbg_data(b_dbg_data), .grant_cnt0(b_cnt0), .grant_cnt1(b_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        RSTN = 1'b0;
        a_req0 = 0; a_req1 = 0; a_addr0 = '0; a_addr1 = '0;
        b_req0 = 0; b_req1 = 0; b_addr0 = '0; b_addr1 = '0;
        repeat (2) tick();
        RSTN = 1'b1;
    endtask

    initial begin
        int acks;
        logic [32:0] exp;
        bit done;

        // Reset state
        apply_reset();
        RSTN = 1'b0;
        check("rst_dbg_addr", a_dbg_addr, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_busy", a_busy, 0);
        check("rst_acks", {a_ack0, a_ack1}, 0);
        check("rst_cnt", {a_cnt0, a_cnt1}, 0);
        RSTN = 1'b1;
        tick();

        // Single read, READ_LAT=1
        a_req0 = 1; a_addr0 = 7'h05;
        check("single_c0_busy", a_busy, 0);
        tick();
        check("single_c1_addr", a_dbg_addr, 7'h05);
        check("single_c1_busy", a_busy, 1);
        check("single_c1_ack", a_ack0, 0);
        tick();
        check("single_c2_ack0", a_ack0, 1);
        check("single_c2_ack1", a_ack1, 0);
        check("single_c2_rdata", a_rdata, 32'hDEAD0005);
        check("single_c2_busy", a_busy, 0);
        a_req0 = 0;
        tick();
        check("single_c3_ack0", a_ack0, 0);
        check("single_c3_busy", a_busy, 0);
        check("single_hold_addr", a_dbg_addr, 7'h05);

        // Mid-transaction reset
        a_req0 = 1; a_addr0 = 7'h33;
        tick();
        RSTN = 1'b0; a_req0 = 0;
        tick();
        check("mrst_dbg_addr", a_dbg_addr, 0);
        check("mrst_rdata", a_rdata, 0);
        check("mrst_busy", a_busy, 0);
        RSTN = 1'b1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_ack0 || a_ack1) acks++;
            tick();
        end
        check("mrst_no_ack", acks, 0);
        a_req0 = 1; a_addr0 = 7'h0A;
        tick();
        tick();
        check("post_rst_ack0", a_ack0, 1);
        check("post_rst_rdata", a_rdata, 32'hDEAD000A);
        a_req0 = 0;
        tick();

        // Withdraw request and change address after grant
        a_req1 = 1; a_addr1 = 7'h11;
        tick();
        check("wd_c1_addr", a_dbg_addr, 7'h11);
        a_req1 = 0; a_addr1 = 7'h22;
        tick();
        check("wd_c2_ack1", a_ack1, 1);
        check("wd_c2_ack0", a_ack0, 0);
        check("wd_c2_rdata", a_rdata, 32'hDEAD0011);
        tick();
        check("wd_c3_ack1", a_ack1, 0);

        // Latency parameter: READ_LAT=3 instance
        b_req1 = 1; b_addr1 = 7'h7F;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("lat3_c%0d_busy", c), b_busy, 1);
            check($sformatf("lat3_c%0d_ack", c), b_ack1, 0);
        end
        check("lat3_addr", b_dbg_addr, 7'h7F);
        tick();
        check("lat3_c4_ack1", b_ack1, 1);
        check("lat3_c4_rdata", b_rdata, 32'hDEAD007F);
        check("lat3_c4_busy", b_busy, 0);
        b_req1 = 0;
        tick();
        check("lat3_c5_ack1", b_ack1, 0);

        // Priority and starvation: 15 x req0, one req1, then req0 again
        apply_reset();
        for (int i = 0; i < 15; i++) exp_q.push_back({1'b0, 32'hDEAD0001});
        exp_q.push_back({1'b1, 32'hDEAD0002});
        exp_q.push_back({1'b0, 32'hDEAD0001});
        a_req0 = 1; a_addr0 = 7'h01;
        a_req1 = 1; a_addr1 = 7'h02;
        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (a_ack0 && a_ack1) check("prio_both_acks", {a_ack0, a_ack1}, 2'b00);
            if (a_ack0 || a_ack1) begin
                exp = exp_q.pop_front();
                check("prio_ack", {a_ack1, a_rdata}, exp);
                if (a_ack1) begin
`ifdef DEBUG_ARB_STATS_EN
                    check("stats_cnt0", a_cnt0, 15);
                    check("stats_cnt1", a_cnt1, 1);
`else
                    check("stats_cnt0_off", a_cnt0, 0);
                    check("stats_cnt1_off", a_cnt1, 0);
`endif
                    a_req1 = 0;
                end
                if (exp_q.size() == 0) done = 1;
            end
        end
        check("prio_all_acks_seen", exp_q.size(), 0);
        a_req0 = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_port_arbiter.md
# debug_port_arbiter

Shares the single CPU debug read port (`debug_addr` out / `debug_data` in of the SCPU core) between two requesters: the VGA debug overlay (requester 0, latency-critical) and a secondary host/7-segment reader (requester 1). It issues one read at a time, waits the port's fixed read latency, captures the data, and returns it with a one-cycle acknowledge. Requester 0 has fixed priority. A starvation counter guarantees requester 1 a grant. The block sits at top level between `SCPU_More`'s debug port and its consumers.

## Interface
- `ADDR_W`, default 7: debug address width.
- `DATA_W`, default 32: debug data width.
- `READ_LAT`, default 1: number of cycles from a stable `dbg_addr` to valid `dbg_data`; legal range 1..7.
- `STARVE_MAX`, default 15: number of lost arbitrations after which requester 1 wins; legal range 1..255.

- `clk` in 1: the single clock; all logic is clocked on its rising edge.
- `RSTN` in 1: reset, synchronous and active-low.
- `req0`, `req1` in 1 each: read requests.
- `addr0`, `addr1` in `ADDR_W` each: requested addresses, sampled at grant.
- `ack0`, `ack1` out 1 each: one-cycle pulse, asserted while `rdata` is valid for that requester.
- `rdata` out `DATA_W`: captured read data, shared by both requesters.
- `busy` out 1: high while a transaction is outstanding.
- `dbg_addr` out `ADDR_W`: registered address driven to the CPU debug port.
- `dbg_data` in `DATA_W`: data returned by the CPU debug port.
- `grant_cnt0`, `grant_cnt1` out 16 each: grant statistics (see Configuration).

## Operation
- The FSM has two states, IDLE and WAIT, plus a latency counter `lat_cnt` that is 3 bits wide.
- **IDLE:**
  - If either request is high, arbitrate.
  - Latch the winner's address into `dbg_addr`, record the winner id, set `lat_cnt = READ_LAT-1`, and go to WAIT.
  - `busy` goes high on the next cycle.
- **Arbitration:**
  - Only `req0` high: requester 0 wins.
  - Only `req1` high: requester 1 wins.
  - Both high and `starve < STARVE_MAX`: requester 0 wins, and `starve` increments.
  - Both high and `starve == STARVE_MAX`: requester 1 wins.
  - `starve` clears whenever requester 1 is granted. It saturates and never wraps.
- **WAIT:**
  - If `lat_cnt != 0`, decrement it.
  - If `lat_cnt == 0`, register `dbg_data` into `rdata`, pulse the winner's ack in the next cycle, and return to IDLE.
- The ack cycle is an IDLE cycle. A request still high during the ack cycle is treated as a new request, which gives back-to-back streaming.
- `dbg_addr` holds its last value while idle. `rdata` holds its value until the next capture.
- Requester handshake rules:
  - A requester keeps `req` high until it sees its ack.
  - If `req` drops mid-transaction, the transaction still completes and the ack still pulses.
  - Changing `addr` after grant has no effect on the current read.
- Reset while `RSTN` is low has priority over all other behaviour:
  - State goes to IDLE and the transaction is abandoned; no ack is issued.
  - `dbg_addr = 0`, `rdata = 0`, `ack0 = ack1 = 0`, `busy = 0`, `starve = 0`, `lat_cnt = 0`, and grant counters = 0.

## Timing
- A request sampled in IDLE in cycle T:
  - `dbg_addr` is valid from T+1.
  - `dbg_data` is sampled at the end of cycle T+READ_LAT.
  - The ack and `rdata` are valid in cycle T+READ_LAT+1.
- Latency is READ_LAT+1 cycles. With READ_LAT=1, a request at cycle 0 is acknowledged in cycle 2.
- Throughput for continuous requests is one read per READ_LAT+1 cycles.
- `busy` is high from T+1 through T+READ_LAT and low in the ack cycle.
- `ack0` and `ack1` are never high together.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `DEBUG_ARB_STATS_EN`.
- Defined:
  - `grant_cnt0` and `grant_cnt1` count grants per requester.
  - They are 16-bit and saturate at 0xFFFF.
  - Each increments in the cycle after its grant decision.
  - They clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is generated. The port list is identical in both cases.

## Structure
- Shared package `debug_arb_pkg` holds:
  - the state enum typedef (IDLE, WAIT);
  - the requester-id typedef, 1 bit;
  - the localparam `GRANT_CNT_W = 16`.
- One sub-module, `debug_arb_stats`, holds the two saturating grant counters. It is instantiated only under `DEBUG_ARB_STATS_EN`.
- Arbitration and the FSM stay in the top module.

## Test plan
- **Single read:** READ_LAT=1. `req0=1`, `addr0=0x05` at cycle 0, and the port model returns 0xDEAD0005. Expect `dbg_addr=0x05` at cycle 1; `ack0=1` and `rdata=0xDEAD0005` at cycle 2; `busy` high only in cycle 1.
- **Priority:** both requests high from cycle 0 with `addr0=0x01` and `addr1=0x02`, requester 0 holding continuously. Expect 15 consecutive `ack0` pulses, then exactly one `ack1` with data for 0x02, then requester 0 resumes.
- **Latency parameter:** READ_LAT=3 with a single `req1`, `addr1=0x7F`. Expect `ack1` at cycle 4 and `rdata` equal to the port value for 0x7F; `busy` high in cycles 1–3.
- **Mid-transaction reset:** `RSTN` low at cycle 1 of a read. Expect no ack ever for that read; in the next cycle `dbg_addr=0`, `rdata=0`, `busy=0`; a new `req0` after reset completes normally.
- **Withdraw and address change:** `req1` dropped and `addr1` changed in cycle 1 after grant. Expect `ack1` still at cycle 2 with data for the originally latched address.
- **Statistics:** with `DEBUG_ARB_STATS_EN` defined, after the priority test expect `grant_cnt1=1` and `grant_cnt0=15`. Without the macro, both counters read 0.
